// File: rtl/fetch_decode_buffer_pkg.sv
// Shared types and default widths for the fetch/decode instruction queue.
package fetch_pkg;

  localparam int FETCH_DEF_WIDTH       = 8;
  localparam int FETCH_DEF_INSTR_WIDTH = 32;
  localparam int FETCH_DEF_DEPTH       = 4;

  // A redirect wins over any push or pop in the same cycle.
  localparam logic FLUSH_PRIO = 1'b1;

  typedef struct packed {
    logic [FETCH_DEF_INSTR_WIDTH-1:0] instr;
    logic [FETCH_DEF_WIDTH-1:0]       pc;
    logic [FETCH_DEF_WIDTH-1:0]       pc_plus8;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
interface fetch_decode_buffer_if #(
  parameter int WIDTH       = 8,
  parameter int INSTR_WIDTH = 32
);
  logic                   flush;
  logic                   in_valid;
  logic [WIDTH-1:0]       PCF;
  logic [WIDTH-1:0]       PCPlus8F;
  logic [INSTR_WIDTH-1:0] InstrF;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] InstrD;
  logic [WIDTH-1:0]       PCD;
  logic [WIDTH-1:0]       PCPlus8D;

  modport master (
    output flush, in_valid, PCF, PCPlus8F, InstrF, out_ready,
    input  in_ready, out_valid, InstrD, PCD, PCPlus8D
  );

  modport slave (
    input  flush, in_valid, PCF, PCPlus8F, InstrF, out_ready,
    output in_ready, out_valid, InstrD, PCD, PCPlus8D
  );
endinterface

// File: rtl/fetch_decode_buffer_ram.sv
// fetch_buf_ram: DEPTH x entry register array, one synchronous write port,
// one asynchronous read port, cleared on reset.
module fetch_buf_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH   = FETCH_DEF_DEPTH,
  parameter int ENTRY_W = FETCH_DEF_INSTR_WIDTH + 2 * FETCH_DEF_WIDTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  // Entry storage; never cleared by a flush, only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {ENTRY_W{1'b0}};
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end else begin
      r_mem <= r_mem;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Instruction queue between Fetch and Decode with redirect flush.
// Optional same-cycle forwarding when empty: define FETCH_BUF_BYPASS_EN.
module fetch_decode_buffer
  import fetch_pkg::*;
#(
  parameter int WIDTH       = FETCH_DEF_WIDTH,
  parameter int INSTR_WIDTH = FETCH_DEF_INSTR_WIDTH,
  parameter int DEPTH       = FETCH_DEF_DEPTH
) (
  input logic                  clk,
  input logic                  reset,
  fetch_decode_buffer_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = INSTR_WIDTH + 2 * WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_in_ready;
  logic               w_empty;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  logic [ENTRY_W-1:0] w_head;

  // in_ready depends on registered occupancy only, so a pop from full
  // reopens the input one cycle later.
  assign w_in_ready = (r_count != FULL_CNT);
  assign w_empty    = (r_count == {CNT_W{1'b0}});
  assign w_wdata    = {bus.InstrF, bus.PCF, bus.PCPlus8F};

`ifdef FETCH_BUF_BYPASS_EN
  logic w_byp;
  assign w_byp       = w_empty & bus.in_valid & ~bus.flush;
  assign w_out_valid = (~w_empty | bus.in_valid) & ~bus.flush;
  // A forwarded beat that Decode takes immediately is never written.
  assign w_push      = bus.in_valid & w_in_ready & ~bus.flush & ~(w_byp & bus.out_ready);
  assign w_pop       = ~w_empty & bus.out_ready & ~bus.flush;
  assign w_head      = w_byp ? w_wdata : w_rdata;
`else
  assign w_out_valid = ~w_empty & ~bus.flush;
  assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_pop       = w_out_valid & bus.out_ready;
  assign w_head      = w_rdata;
`endif

  // Pointer and occupancy update; a flush empties the queue at the write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (bus.flush) begin
      r_wr_ptr <= r_wr_ptr;
      r_rd_ptr <= r_wr_ptr;
      r_count  <= {CNT_W{1'b0}};
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
      r_rd_ptr <= w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fetch_buf_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.InstrD    = w_head[ENTRY_W-1 -: INSTR_WIDTH];
  assign bus.PCD       = w_head[2*WIDTH-1 -: WIDTH];
  assign bus.PCPlus8D  = w_head[WIDTH-1:0];

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed, table-driven bench for fetch_decode_buffer (DEPTH = 4).
module tb_fetch_decode_buffer;
  import fetch_pkg::*;

`ifdef FETCH_BUF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed {
    logic       iv;
    logic       fl;
    logic       ordy;
    logic [7:0] pc;
    logic       exp_ir;
    logic       exp_ov;
    logic [7:0] exp_pcd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_decode_buffer_if #(.WIDTH(8), .INSTR_WIDTH(32)) bus ();

  fetch_decode_buffer #(.WIDTH(8), .INSTR_WIDTH(32), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic fetch_entry_t mk(input logic [7:0] pc);
    fetch_entry_t e;
    e.instr    = {24'hC0DE00, pc};
    e.pc       = pc;
    e.pc_plus8 = pc + 8'd8;
    return e;
  endfunction

  task automatic drive(input logic iv, input logic fl, input logic ordy, input logic [7:0] pc);
    fetch_entry_t e;
    e = mk(pc);
    bus.in_valid  = iv;
    bus.flush     = fl;
    bus.out_ready = ordy;
    bus.PCF       = e.pc;
    bus.PCPlus8F  = e.pc_plus8;
    bus.InstrF    = e.instr;
  endtask

  task automatic check_head(input string name, input logic [7:0] pc);
    fetch_entry_t e;
    e = mk(pc);
    check({name, "_ov"},    32'(bus.out_valid), 32'd1);
    check({name, "_pcd"},   32'(bus.PCD),       32'(e.pc));
    check({name, "_pc8"},   32'(bus.PCPlus8D),  32'(e.pc_plus8));
    check({name, "_instr"}, bus.InstrD,         e.instr);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // iv, fl, ordy, pc, exp in_ready, exp out_valid, exp PCD (pre-edge view)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, BYP,  8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h18, 1'b1, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h08};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h10};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h18};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h30, 1'b1, BYP,  8'h30};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h38, 1'b1, 1'b1, 8'h30};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h40, 1'b1, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h80, 1'b1, BYP,  8'h80};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h80};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ir",    32'(bus.in_ready),  32'd1);
    check("rst_ov",    32'(bus.out_valid), 32'd0);
    check("rst_pcd",   32'(bus.PCD),       32'd0);
    check("rst_pc8",   32'(bus.PCPlus8D),  32'd0);
    check("rst_instr", bus.InstrD,         32'd0);
    check("rst_count", 32'(dut.r_count),   32'd0);
    next_cycle();

    // Fill to full, drain in order, then flush with a discarded beat.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].iv, tbl[i].fl, tbl[i].ordy, tbl[i].pc);
      @(negedge clk);
      check($sformatf("vec%0d_ir", i), 32'(bus.in_ready),  32'(tbl[i].exp_ir));
      check($sformatf("vec%0d_ov", i), 32'(bus.out_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) check_head($sformatf("vec%0d", i), tbl[i].exp_pcd);
      @(posedge clk);
      #1;
    end

    // Pointer wrap: one entry resident, then 10 push+pop beats.
    drive(1'b1, 1'b0, 1'b0, 8'h50);
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h58 + 8'(8 * k));
      #3;
      check_head($sformatf("wrap%0d", k), 8'h50 + 8'(8 * k));
      next_cycle();
      check($sformatf("wrap%0d_count", k), 32'(dut.r_count), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    #3;
    check_head("wrap_last", 8'hA0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    check("wrap_empty_ov", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset in the middle of a cycle after three pushes.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h60 + 8'(8 * k));
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    reset = 1'b0;
    #1;
    check("mrst_ov",  32'(bus.out_valid), 32'd0);
    check("mrst_ir",  32'(bus.in_ready),  32'd1);
    check("mrst_pcd", 32'(bus.PCD),       32'd0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 8'h10);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    check_head("mrst_first", 8'h10);
    check("mrst_count", 32'(dut.r_count), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    check("mrst_drained", 32'(bus.out_valid), 32'd0);

`ifdef FETCH_BUF_BYPASS_EN
    // Empty queue, Decode ready: same-cycle forward, nothing stored.
    drive(1'b1, 1'b0, 1'b1, 8'h24);
    #3;
    check_head("byp", 8'h24);
    check("byp_count_pre", 32'(dut.r_count), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    check("byp_count", 32'(dut.r_count),   32'd0);
    check("byp_ov",    32'(bus.out_valid), 32'd0);
`else
    // Without forwarding an empty queue shows nothing in the push cycle.
    drive(1'b1, 1'b0, 1'b1, 8'h24);
    #3;
    check("nobyp_ov", 32'(bus.out_valid), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    check_head("nobyp_next", 8'h24);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
